// File: rtl/fp_exp_sequencer.sv
// fp_exp_sequencer: multi-cycle exponent path for the FP multiplier.
// Sequences one shared adder/bias-subtractor through add, bias removal and
// normalization, then classifies the result as normal, zero, overflow or
// underflow. Start/done handshake with the ALU control FSM.
module fp_exp_sequencer #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned BIAS  = 127
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [EXP_W-1:0] exp_a,
    input  logic [EXP_W-1:0] exp_b,
    input  logic             norm_valid,
    input  logic             norm_inc,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [EXP_W-1:0] exp_out,
    output logic             zero,
    output logic             ovf,
    output logic             unf
);

    // Sum carries one extra bit (0..2*max); normalized exponent one more.
    localparam int unsigned SUM_W = EXP_W + 1;
    localparam int unsigned E_W   = EXP_W + 2;

    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [SUM_W-1:0] BIAS_C  = SUM_W'(BIAS);
    localparam logic [E_W-1:0]   E_MAX   = E_W'(EXP_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_BIAS,
        S_NORM,
        S_DONE
    } state_t;

    state_t             state;
    logic [EXP_W-1:0]   op_a;
    logic [EXP_W-1:0]   op_b;
    logic [SUM_W-1:0]   sum;
    logic [SUM_W-1:0]   diff;
    logic               borrow;

    logic [E_W-1:0]     e_norm;
    logic [EXP_W-1:0]   cls_exp;
    logic               cls_zero;
    logic               cls_ovf;
    logic               cls_unf;

    // Result classification from captured operands and bias-removed exponent.
    always_comb begin
        cls_exp  = '0;
        cls_zero = 1'b0;
        cls_ovf  = 1'b0;
        cls_unf  = 1'b0;
        e_norm   = {1'b0, diff} + E_W'(norm_inc);

        if (op_a == '0 || op_b == '0) begin
            cls_zero = 1'b1;
        end else if (op_a == EXP_MAX || op_b == EXP_MAX) begin
            cls_ovf = 1'b1;
            cls_exp = EXP_MAX;
        end else if (borrow) begin
            cls_unf = 1'b1;
        end else if (e_norm >= E_MAX) begin
            cls_ovf = 1'b1;
            cls_exp = EXP_MAX;
        end else if (e_norm == '0) begin
            cls_unf = 1'b1;
        end else begin
            cls_exp = e_norm[EXP_W-1:0];
        end
    end

    // Sequencer state, shared datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            op_a    <= '0;
            op_b    <= '0;
            sum     <= '0;
            diff    <= '0;
            borrow  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            exp_out <= '0;
            zero    <= 1'b0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
        end else if (abort && state != S_IDLE) begin
            // Flush: drop the operation silently and clear the result.
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            exp_out <= '0;
            zero    <= 1'b0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    // abort in IDLE drops a simultaneous start.
                    if (start && !abort) begin
                        state   <= S_ADD;
                        busy    <= 1'b1;
                        op_a    <= exp_a;
                        op_b    <= exp_b;
                        exp_out <= '0;
                        zero    <= 1'b0;
                        ovf     <= 1'b0;
                        unf     <= 1'b0;
                    end
                end
                S_ADD: begin
                    sum   <= SUM_W'(op_a) + SUM_W'(op_b);
                    state <= S_BIAS;
                end
                S_BIAS: begin
                    {borrow, diff} <= {1'b0, sum} - {1'b0, BIAS_C};
                    state          <= S_NORM;
                end
                S_NORM: begin
                    if (norm_valid) begin
                        exp_out <= cls_exp;
                        zero    <= cls_zero;
                        ovf     <= cls_ovf;
                        unf     <= cls_unf;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/fp_exp_sequencer.md
# fp_exp_sequencer

Multi-cycle controller for the floating-point multiplier exponent path. It sequences one shared 9-bit adder/bias-subtractor datapath through three steps: exponent add, IEEE-754 single-precision bias removal (−127), and normalization increment. It then classifies the result as normal, zero, overflow or underflow. It sits between the operand-unpack stage and the mantissa multiplier, and uses a start/done handshake with the ALU control FSM.

## Interface
- Parameters:
  - EXP_W, default 8: exponent width.
  - BIAS, default 127: bias subtracted. The 9-bit constant is 001111111.
- Ports:
  - clk, input, 1: single clock; all state updates on the rising edge.
  - rst_n, input, 1: asynchronous, active-low reset.
  - start, input, 1: operation request. Sampled only in IDLE.
  - exp_a, input, 8: biased exponent of operand A, captured on the start edge.
  - exp_b, input, 8: biased exponent of operand B, captured on the start edge.
  - norm_valid, input, 1: mantissa multiplier result ready.
  - norm_inc, input, 1: mantissa product ≥ 2.0, so the exponent needs +1. Sampled only with norm_valid.
  - abort, input, 1: synchronous flush to IDLE.
  - busy, output, 1: high in every state except IDLE.
  - done, output, 1: one-cycle pulse when the result is valid.
  - exp_out, output, 8: result biased exponent.
  - zero, output, 1: at least one operand exponent was 0; result is zero.
  - ovf, output, 1: result exponent ≥ 255, or an operand exponent was 255.
  - unf, output, 1: result exponent ≤ 0.

## Operation
- States:
  - IDLE → ADD on start=1. Operands are captured in this transition.
  - ADD → BIAS. sum[8:0] = exp_a + exp_b (zero-extended to 9 bits; range 0..510).
  - BIAS → NORM. {borrow, diff[8:0]} = sum − BIAS (9-bit subtract with borrow-out).
  - NORM → DONE when norm_valid=1, sampling norm_inc. NORM holds indefinitely while norm_valid=0.
  - DONE → IDLE unconditionally. done=1 only while in DONE.
- Result classification, computed in the NORM→DONE transition with priority top-down:
  1. Either captured operand = 0: zero=1, exp_out=0, ovf=unf=0.
  2. Either captured operand = 255: ovf=1, exp_out=255.
  3. borrow=1 (sum < 127): unf=1, exp_out=0.
  4. e = diff + norm_inc (10-bit). If e ≥ 255: ovf=1, exp_out=255.
  5. If e = 0: unf=1, exp_out=0 (flush denormal).
  6. Otherwise exp_out = e[7:0], all flags 0.
- Output holding:
  - exp_out, zero, ovf and unf are registered.
  - They hold their values after DONE until the next start is accepted.
  - They clear to 0 on the ADD entry edge.
- start while busy=1 is ignored; no queuing.
- abort=1 in any non-IDLE state returns to IDLE on the next edge:
  - exp_out and all flags clear to 0.
  - done is not pulsed.
  - abort takes priority over norm_valid in the same cycle.
- start and abort both high in IDLE: abort wins and start is dropped.

## Timing
- Reset (rst_n=0) forces all of the following immediately, without waiting for a clock:
  - state=IDLE
  - busy=0, done=0
  - exp_out=0, zero=0, ovf=0, unf=0
  - internal sum, diff and borrow = 0
- Reset mid-operation discards the operation; no done pulse follows.
- Latency: start accepted at edge T0.
  - ADD during T0–T1, BIAS during T1–T2, NORM from T2.
  - If norm_valid=1 in the cycle after T2, DONE occupies the cycle after edge T3: done rises 3 cycles after the start edge.
  - Each extra NORM wait cycle adds one cycle.
- busy rises the cycle after the start edge and falls the cycle after DONE. Minimum start-to-start spacing is 5 cycles.
- norm_inc is ignored outside the NORM cycle in which norm_valid=1.

## Test plan
- exp_a=127, exp_b=127, norm_valid=1 at T2, norm_inc=0 → done at T3+1, exp_out=127, all flags 0. Repeat with norm_inc=1 → exp_out=128.
- exp_a=190, exp_b=191, norm_inc=1 → diff=254, e=255 → ovf=1, exp_out=255. Also exp_a=200, exp_b=200 → ovf=1.
- exp_a=10, exp_b=20 → borrow=1 → unf=1, exp_out=0. Also exp_a=64, exp_b=63 with norm_inc=0 → unf=1; with norm_inc=1 → exp_out=1, no flags.
- exp_a=0, exp_b=150 → zero=1, exp_out=0. Also exp_a=255, exp_b=0 → zero=1, ovf=0 (zero has priority).
- Hold norm_valid=0 for 6 cycles → state stays NORM, busy=1, done=0; then norm_valid=1 → done next cycle. Pulse start during the wait → ignored, result matches the first operands.
- abort in BIAS → IDLE next edge, no done, outputs 0. rst_n low in NORM → outputs 0 immediately, busy=0. A subsequent start completes normally.
